// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipelined processor: the machine word, the branch
// predictor counter, the IF/ID latch record and the NOP/bubble constants.
// Also provides the 2-bit saturating counter step used by the predictor.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // 2-bit saturating branch counter; MSB is the taken prediction
  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_WNT   = 2'b01;
  localparam word_t    NOP_INSTR = 32'h0000_0000;

  // IF/ID pipeline latch contents
  typedef struct packed {
    word_t instruction;
    word_t instr_npc;
    logic  branch_taken;
    logic  valid;
  } ifid_t;

  // An empty IF/ID slot: sll r0 NOP, no prediction, not valid
  localparam ifid_t IFID_BUBBLE = '{
    instruction:  NOP_INSTR,
    instr_npc:    32'h0000_0000,
    branch_taken: 1'b0,
    valid:        1'b0
  };

  // One training step of a saturating counter toward the resolved outcome
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t result;
    result = ctr;
    if (taken) begin
      if (ctr != 2'b11) result = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) result = ctr - 2'b01;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped table of 2-bit saturating counters.
//   CLK, nRST  : clock, asynchronous active-low reset (all counters -> 01)
//   rd_idx     : index of the PC being fetched
//   rd_taken   : combinational prediction (counter MSB) for rd_idx
//   upd_en     : train one counter this cycle
//   upd_idx    : index of the resolved branch
//   upd_taken  : resolved direction
// A read of the entry being trained in the same cycle sees the old value,
// since the write only lands at the clock edge.
// ---------------------------------------------------------------------------
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_ctr_t ctr_q [ENTRIES];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
    end
  end

  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: holds the PC, issues instruction-memory reads, predicts
// branch direction, and registers fetched words into the IF/ID latch.
//   CLK, nRST          : clock, asynchronous active-low reset
//   imemREN, imemaddr  : read enable (high out of reset) and address (= PC)
//   imemload, ihit     : returned word and its valid strobe
//   stall, flush       : hold PC+IF/ID / squash IF/ID
//   ex_redirect/target : execute-stage correction (highest priority)
//   dec_redirect       : decode-side taken redirect to branch_target
//   bp_update/pc/taken : predictor training from resolved branches
//   instruction, instr_npc, branch_taken, instr_valid : IF/ID outputs
// Without a BTB, fetch always proceeds to PC+4; a predicted-taken branch is
// turned into a redirect by decode one cycle later.
// ---------------------------------------------------------------------------
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT     = 32'h0000_0000,
  parameter int    BHT_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        dec_redirect,
  input  logic [31:0] branch_target,
  input  logic        bp_update,
  input  logic [31:0] bp_pc,
  input  logic        bp_taken,
  output logic [31:0] instruction,
  output logic [31:0] instr_npc,
  output logic        branch_taken,
  output logic        instr_valid
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  word_t pc_q, pc_next, pc_plus4;
  ifid_t ifid_q, ifid_next;
  logic  predict_taken;
  logic  unused_bp_pc_bits;

  assign pc_plus4 = pc_q + 32'd4;

  // Only the index bits of the resolved branch PC select a counter
  assign unused_bp_pc_bits = ^{bp_pc[31:IDX_W+2], bp_pc[1:0]};

  branch_predictor #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .CLK       (CLK),
    .nRST      (nRST),
    .rd_idx    (pc_q[IDX_W+1:2]),
    .rd_taken  (predict_taken),
    .upd_en    (bp_update),
    .upd_idx   (bp_pc[IDX_W+1:2]),
    .upd_taken (bp_taken)
  );

  // PC selection: redirects beat stall; a miss simply keeps the request up
  always_comb begin
    pc_next = pc_q;
    if (ex_redirect)       pc_next = ex_target;
    else if (dec_redirect) pc_next = branch_target;
    else if (stall)        pc_next = pc_q;
    else if (ihit)         pc_next = pc_plus4;
  end

  // IF/ID selection: any redirect or flush squashes the slot even under
  // stall, which drops the fall-through word fetched behind a taken branch
  always_comb begin
    ifid_next = IFID_BUBBLE;
    if (ex_redirect || flush || dec_redirect) begin
      ifid_next = IFID_BUBBLE;
    end else if (stall) begin
      ifid_next = ifid_q;
    end else if (ihit) begin
      ifid_next.instruction  = imemload;
      ifid_next.instr_npc    = pc_plus4;
      ifid_next.branch_taken = predict_taken;
      ifid_next.valid        = 1'b1;
    end
  end

  // PC and IF/ID registers; reset abandons any fetch in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q   <= PC_INIT;
      ifid_q <= IFID_BUBBLE;
    end else begin
      pc_q   <= pc_next;
      ifid_q <= ifid_next;
    end
  end

  assign imemREN      = nRST;
  assign imemaddr     = pc_q;
  assign instruction  = ifid_q.instruction;
  assign instr_npc    = ifid_q.instr_npc;
  assign branch_taken = ifid_q.branch_taken;
  assign instr_valid  = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage with hand-computed
// expectations, plus a hand-written reset-during-miss sequence.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload = '0;
  logic        ihit = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic        dec_redirect = 1'b0;
  logic [31:0] branch_target = '0;
  logic        bp_update = 1'b0;
  logic [31:0] bp_pc = '0;
  logic        bp_taken = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_npc;
  logic        branch_taken;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  ihit;
    word_t load;
    logic  stall;
    logic  flush;
    logic  exr;
    word_t ext;
    logic  decr;
    word_t bt;
    logic  bpu;
    word_t bpc;
    logic  bpt;
    word_t eAddr;
    word_t eInstr;
    word_t eNpc;
    logic  eTaken;
    logic  eValid;
  } vec_t;

  vec_t vecs[$];

  fetch_stage #(
    .PC_INIT     (32'h0000_0000),
    .BHT_ENTRIES (16)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .imemload      (imemload),
    .ihit          (ihit),
    .stall         (stall),
    .flush         (flush),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .dec_redirect  (dec_redirect),
    .branch_target (branch_target),
    .bp_update     (bp_update),
    .bp_pc         (bp_pc),
    .bp_taken      (bp_taken),
    .instruction   (instruction),
    .instr_npc     (instr_npc),
    .branch_taken  (branch_taken),
    .instr_valid   (instr_valid)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLK = ~CLK;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input word_t eAddr, input word_t eInstr,
                             input word_t eNpc, input logic eTaken, input logic eValid);
    checkVal({tag, " imemaddr"}, imemaddr, eAddr);
    checkVal({tag, " instruction"}, instruction, eInstr);
    checkVal({tag, " instr_npc"}, instr_npc, eNpc);
    checkVal({tag, " branch_taken"}, {31'b0, branch_taken}, {31'b0, eTaken});
    checkVal({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, eValid});
  endtask

  task automatic addVec(input logic ih, input word_t ld, input logic st, input logic fl,
                        input logic exr, input word_t ext, input logic decr, input word_t bt,
                        input logic bpu, input word_t bpc, input logic bpt,
                        input word_t eAddr, input word_t eInstr, input word_t eNpc,
                        input logic eTaken, input logic eValid);
    vec_t v;
    v.ihit = ih;   v.load = ld;  v.stall = st; v.flush = fl;
    v.exr = exr;   v.ext = ext;  v.decr = decr; v.bt = bt;
    v.bpu = bpu;   v.bpc = bpc;  v.bpt = bpt;
    v.eAddr = eAddr; v.eInstr = eInstr; v.eNpc = eNpc;
    v.eTaken = eTaken; v.eValid = eValid;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge happen, settle just after it
  task automatic applyStimulus(input vec_t v);
    ihit = v.ihit;          imemload = v.load;
    stall = v.stall;        flush = v.flush;
    ex_redirect = v.exr;    ex_target = v.ext;
    dec_redirect = v.decr;  branch_target = v.bt;
    bp_update = v.bpu;      bp_pc = v.bpc;      bp_taken = v.bpt;
    @(posedge CLK);
    #1;
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v.eAddr, v.eInstr, v.eNpc, v.eTaken, v.eValid);
  endtask

  vec_t rv;

  initial begin
    // Columns: ihit load stall flush | exr ext | decr bt | bpu bpc bpt || addr instr npc taken valid
    // Sequential fetch from reset
    addVec(1, 32'h2001_0005, 0,0, 0,0, 0,0, 0,0,0,  32'h4, 32'h2001_0005, 32'h4, 0,1);
    addVec(1, 32'h2001_0005, 0,0, 0,0, 0,0, 0,0,0,  32'h8, 32'h2001_0005, 32'h8, 0,1);
    // Three wait states at PC 8, then the hit
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 0,0,0,  32'h8, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 0,0,0,  32'h8, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 0,0,0,  32'h8, 32'h0, 32'h0, 0,0);
    addVec(1, 32'hAAAA_0001, 0,0, 0,0, 0,0, 0,0,0,  32'hC, 32'hAAAA_0001, 32'hC, 0,1);
    // Stall holds everything; stall+flush bubbles IF/ID only
    addVec(1, 32'hBBBB_0002, 1,0, 0,0, 0,0, 0,0,0,  32'hC, 32'hAAAA_0001, 32'hC, 0,1);
    addVec(1, 32'hBBBB_0002, 1,0, 0,0, 0,0, 0,0,0,  32'hC, 32'hAAAA_0001, 32'hC, 0,1);
    addVec(1, 32'hBBBB_0002, 1,1, 0,0, 0,0, 0,0,0,  32'hC, 32'h0, 32'h0, 0,0);
    // Train 0x40 (index 0) twice taken: 01 -> 10 -> 11
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'h40,1,  32'hC, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'h40,1,  32'hC, 32'h0, 32'h0, 0,0);
    // Redirect during miss to 0x40, fetch predicted-taken branch
    addVec(0, 32'h0,         0,0, 1,32'h40, 0,0, 0,0,0,  32'h40, 32'h0, 32'h0, 0,0);
    addVec(1, 32'h1000_0003, 0,0, 0,0, 0,0, 0,0,0,  32'h44, 32'h1000_0003, 32'h44, 1,1);
    // Decode confirms: go to 0x100, discard fall-through word
    addVec(1, 32'hDEAD_0000, 0,0, 0,0, 1,32'h100, 0,0,0,  32'h100, 32'h0, 32'h0, 0,0);
    // Fetch at 0x100 (index 0) while training index 0 not-taken: sees old 11
    addVec(1, 32'h1111_0001, 0,0, 0,0, 0,0, 1,32'h0,0,  32'h104, 32'h1111_0001, 32'h104, 1,1);
    addVec(1, 32'h2222_0002, 0,0, 0,0, 0,0, 0,0,0,  32'h108, 32'h2222_0002, 32'h108, 0,1);
    // ex_redirect beats dec_redirect and stall
    addVec(1, 32'h0,         1,0, 1,32'h200, 1,32'h100, 0,0,0,  32'h200, 32'h0, 32'h0, 0,0);
    addVec(1, 32'h3333_0003, 0,0, 0,0, 0,0, 0,0,0,  32'h204, 32'h3333_0003, 32'h204, 1,1);
    // Index 0 now 10: fetch at 0xC0 with a same-cycle not-taken update
    addVec(0, 32'h0,         0,0, 1,32'hC0, 0,0, 0,0,0,  32'hC0, 32'h0, 32'h0, 0,0);
    addVec(1, 32'h4444_0004, 0,0, 0,0, 0,0, 1,32'hC0,0,  32'hC4, 32'h4444_0004, 32'hC4, 1,1);
    // Low saturation: 01 -> 00 -> 00 -> 00 -> 01
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'hC0,0,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'hC0,0,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'hC0,0,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'hC0,1,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 1,32'hC0, 0,0, 0,0,0,  32'hC0, 32'h0, 32'h0, 0,0);
    addVec(1, 32'h5555_0005, 0,0, 0,0, 0,0, 0,0,0,  32'hC4, 32'h5555_0005, 32'hC4, 0,1);
    // High saturation at 0x08 (index 2): 01 -> 10 -> 11 -> 11 -> 10 -> 01
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'h08,1,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'h08,1,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'h08,1,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'h08,0,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 0,0, 0,0, 1,32'h08,0,  32'hC4, 32'h0, 32'h0, 0,0);
    addVec(0, 32'h0,         0,0, 1,32'h08, 0,0, 0,0,0,  32'h08, 32'h0, 32'h0, 0,0);
    addVec(1, 32'h6666_0006, 0,0, 0,0, 0,0, 0,0,0,  32'h0C, 32'h6666_0006, 32'h0C, 0,1);
    // PC wrap at the top of the address space
    addVec(0, 32'h0,         0,0, 1,32'hFFFF_FFFC, 0,0, 0,0,0,  32'hFFFF_FFFC, 32'h0, 32'h0, 0,0);
    addVec(1, 32'h7777_0007, 0,0, 0,0, 0,0, 0,0,0,  32'h0, 32'h7777_0007, 32'h0, 0,1);
    // Flush alone still lets the PC advance on a hit
    addVec(1, 32'h8888_0008, 0,1, 0,0, 0,0, 0,0,0,  32'h4, 32'h0, 32'h0, 0,0);
    // Decode redirect during a miss
    addVec(0, 32'h0,         0,0, 0,0, 1,32'h300, 0,0,0,  32'h300, 32'h0, 32'h0, 0,0);

    // Reset state
    #1;
    checkVal("reset imemREN", {31'b0, imemREN}, 32'h0);
    checkOutput("reset", 32'h0, 32'h0, 32'h0, 0, 0);
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    #1;
    checkVal("release imemREN", {31'b0, imemREN}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      runVec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset mid-miss at PC 0x24 with a valid word held under stall
    rv = '{ihit:0, load:0, stall:0, flush:0, exr:1, ext:32'h20, decr:0, bt:0, bpu:0, bpc:0, bpt:0,
           eAddr:32'h20, eInstr:0, eNpc:0, eTaken:0, eValid:0};
    runVec("r0", rv);
    rv = '{ihit:1, load:32'h9999_0009, stall:0, flush:0, exr:0, ext:0, decr:0, bt:0, bpu:0, bpc:0, bpt:0,
           eAddr:32'h24, eInstr:32'h9999_0009, eNpc:32'h24, eTaken:0, eValid:1};
    runVec("r1", rv);
    rv = '{ihit:0, load:0, stall:1, flush:0, exr:0, ext:0, decr:0, bt:0, bpu:1, bpc:32'h24, bpt:1,
           eAddr:32'h24, eInstr:32'h9999_0009, eNpc:32'h24, eTaken:0, eValid:1};
    runVec("r2", rv);
    runVec("r3", rv);
    stall = 1'b0;
    bp_update = 1'b0;
    #3;
    nRST = 1'b0;
    #1;
    checkVal("midreset imemREN", {31'b0, imemREN}, 32'h0);
    checkOutput("midreset", 32'h0, 32'h0, 32'h0, 0, 0);
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    #1;
    checkVal("rerelease imemREN", {31'b0, imemREN}, 32'h1);
    checkVal("rerelease imemaddr", imemaddr, 32'h0);
    rv = '{ihit:1, load:32'hABCD_0001, stall:0, flush:0, exr:0, ext:0, decr:0, bt:0, bpu:0, bpc:0, bpt:0,
           eAddr:32'h4, eInstr:32'hABCD_0001, eNpc:32'h4, eTaken:0, eValid:1};
    runVec("r4", rv);
    // Index 9 was trained to 11 before reset; it must be back at 01
    rv = '{ihit:0, load:0, stall:0, flush:0, exr:1, ext:32'h24, decr:0, bt:0, bpu:0, bpc:0, bpt:0,
           eAddr:32'h24, eInstr:0, eNpc:0, eTaken:0, eValid:0};
    runVec("r5", rv);
    rv = '{ihit:1, load:32'h1234_0001, stall:0, flush:0, exr:0, ext:0, decr:0, bt:0, bpu:0, bpc:0, bpt:0,
           eAddr:32'h28, eInstr:32'h1234_0001, eNpc:32'h28, eTaken:0, eValid:1};
    runVec("r6", rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
